// File: rtl/alu_seq_n.sv
// alu_seq_n: handshaked sequential ALU with registered result and flags.
//
// Operations are accepted on a valid/ready input port. All ops except MUL
// finish one cycle after they are accepted. MUL is an iterative shift-add
// multiplier that takes WIDTH iterations. Results leave on a valid/ready
// output port and hold while the consumer applies backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   op, a, b            operation code and 2's-complement operands
//   out_valid, out_ready output handshake
//   result              registered WIDTH-bit result
//   carryout, overflow  registered carry / signed-overflow flags
//   zero                registered, 1 when result == 0
//
// state | meaning
// IDLE  | waiting for an operation
// BUSY  | multiplier iterating (WIDTH iterations)
// DONE  | result presented, waiting for out_ready
module alu_seq_n #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW    = $clog2(WIDTH + 1);
  localparam bit MulOn = (MUL_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic               accept;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic               ovf_add;
  logic               ovf_sub;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] acc_step;

  // Ready in DONE when the consumer retires the current result, so a new
  // op can be accepted in the same cycle as the output handshake.
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (sum_add[WIDTH-1] ^ a[WIDTH-1]) & (sum_add[WIDTH-1] ^ b[WIDTH-1]);
  assign ovf_sub = (sum_sub[WIDTH-1] ^ a[WIDTH-1]) & (sum_sub[WIDTH-1] ^ ~b[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      3'd0: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = ovf_add;
      end
      3'd1: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = ovf_sub;
      end
      3'd2: alu_res = a ^ b;
      3'd3: alu_res = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
      3'd4: alu_res = a & b;
      3'd5: alu_res = ~(a | b);
      3'd6: alu_res = a | b;
      default: alu_res = '0;  // op 7 without multiplier
    endcase
  end

  // One multiplier iteration: the multiplier sits in the low half of the
  // accumulator; add the multiplicand into the high half when bit 0 is set,
  // then shift the whole (2*WIDTH+1)-bit value right by one.
  assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_add, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_q  <= S_DONE;
        valid_q  <= 1'b1;
        result_q <= acc_step[WIDTH-1:0];
        carry_q  <= |acc_step[2*WIDTH-1:WIDTH];
        ovf_q    <= 1'b0;
        zero_q   <= (acc_step[WIDTH-1:0] == '0);
      end
    end else if (accept) begin
      if ((op == 3'd7) && MulOn) begin
        state_q <= S_BUSY;
        valid_q <= 1'b0;
        mcand_q <= a;
        acc_q   <= {{WIDTH{1'b0}}, b};
        cnt_q   <= CW'(WIDTH);
      end else begin
        state_q  <= S_DONE;
        valid_q  <= 1'b1;
        result_q <= alu_res;
        carry_q  <= alu_c;
        ovf_q    <= alu_v;
        zero_q   <= (alu_res == '0);
      end
    end else if ((state_q == S_DONE) && out_ready) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_n.sv
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, carryout, overflow, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definitions; returns {zero, ovf, carry, result}.
  function automatic logic [34:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, s;
    logic [63:0] ux, uy, full;
    logic [31:0] r;
    logic        c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: begin
        full = ux + uy; r = full[31:0]; c = full[32];
        s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = x - y; c = (ux >= uy);
        s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = x ^ y;
      3'd3: r = (sx < sy) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = ~(x | y);
      3'd6: r = x | y;
      default: begin
        full = ux * uy; r = full[31:0]; c = (full[63:32] != 0);
      end
    endcase
    return {(r == 0), v, c, r};
  endfunction

  // Presents one op from IDLE, checks latency, BUSY behaviour and the result, then retires it.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [34:0] exp);
    int n;
    bit busy_ok;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    n = 1;
    busy_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), (o == 3'd7) ? 64'd33 : 64'd1);
    if (o == 3'd7) chk({tag, "_busy_in_ready"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_result"}, {29'd0, zero, overflow, carryout, result}, {29'd0, exp});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_retired"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] specials [5];
    logic [31:0] x, y;
    logic [2:0]  o;
    bit          ok;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {28'd0, out_valid, zero, overflow, carryout, result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed ops
    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h1, {1'b0, 1'b1, 1'b0, 32'h80000000});
    run_op("sub_eq", 3'd1, 32'd5, 32'd5, {1'b1, 1'b0, 1'b1, 32'h0});
    run_op("slt_neg", 3'd3, 32'hFFFFFFFF, 32'h1, {1'b0, 1'b0, 1'b0, 32'h1});
    run_op("slt_ovf", 3'd3, 32'h80000000, 32'h1, {1'b0, 1'b0, 1'b0, 32'h1});
    run_op("slt_false", 3'd3, 32'h1, 32'hFFFFFFFF, {1'b1, 1'b0, 1'b0, 32'h0});
    run_op("nor_zero", 3'd5, 32'h0, 32'h0, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFF});
    run_op("mul_wrap", 3'd7, 32'h00010000, 32'h00010000, {1'b1, 1'b0, 1'b1, 32'h0});
    run_op("mul_small", 3'd7, 32'd7, 32'd6, {1'b0, 1'b0, 1'b0, 32'd42});

    // Backpressure: ADD result held while a second op waits
    in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_first", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd12});
    op = 3'd1; a = 32'd100; b = 32'd1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({out_valid, in_ready, zero, overflow, carryout, result} !== {1'b1, 1'b0, 3'b000, 32'd12})
        ok = 1'b0;
    end
    chk("bp_stable", {63'd0, ok}, 64'd1);

    // Output handshake and new accept in the same cycle, no bubble
    op = 3'd2; a = 32'hF0F0F0F0; b = 32'hFFFFFFFF; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_xor", {28'd0, out_valid, zero, overflow, carryout, result},
        {28'd0, 1'b1, 3'b000, 32'h0F0F0F0F});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      run_op("rand", o, x, y, model(o, x, y));
    end

    // Reset in the middle of a multiply; previous result is nonzero
    run_op("pre_rst", 3'd6, 32'h00F0, 32'h0F00, model(3'd6, 32'h00F0, 32'h0F00));
    in_valid = 1'b1; op = 3'd7; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {31'd0, out_valid, result}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("midrst_no_stale", {63'd0, ok}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
